ram_readback_if: RTL
====================

// Module: ram_readback_if
// PURPOSE
//  Read-out stage downstream of the 8-bit counter fill stage and its 64K x 8 on-chip RAM.
//  After the fill stage reports fill_done, this block serves Arduino GPIO read requests.
//  The Arduino drives an asynchronous 4-phase req/ack handshake with a 16-bit address.
//  The block synchronises req, drives the RAM read address, waits the RAM read latency,
//  then returns the byte on ard_data with ard_ack.
//  ram_addr connects to the fill stage's test_inp address port.
// PARAMETERS
//  ADDR_W       16  RAM / Arduino address width
//  DATA_W       8   RAM data width
//  RD_LAT       2   clk edges from ram_addr update until ram_q is stable; range 1..7
//  SYNC_STAGES  2   flops in the ard_req synchroniser; range 2..3
// PORTS
//  clk        in   1       system clock (all logic on posedge)
//  reset_n    in   1       asynchronous, active-low reset
//  fill_done  in   1       high once the fill stage has stopped writing (its wren low)
//  ard_req    in   1       Arduino request, asynchronous to clk
//  ard_addr   in   ADDR_W  Arduino address; stable from before req rise until ack rise
//  ram_q      in   DATA_W  RAM read data
//  ram_addr   out  ADDR_W  registered read address to the RAM path
//  ard_data   out  DATA_W  registered read data to the Arduino
//  ard_ack    out  1       handshake acknowledge
//  busy       out  1       high in any state except IDLE
//  proto_err  out  1       sticky: req fell before ack was given
//  rd_count   out  16      completed (acked) reads, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - All outputs are 0; FSM enters IDLE; wait counter is 0; synchroniser flops are 0.
//   - Reset mid-transaction aborts the transaction immediately, with no ack.
//  Synchroniser
//   - req_s is the output of the SYNC_STAGES flop chain.
//   - ard_addr is not synchronised; it is sampled only on the IDLE->WAIT edge.
//  States: IDLE, WAIT, ACK
//   - IDLE: if req_s=1 and fill_done=1, then ram_addr<=ard_addr, cnt<=RD_LAT, go WAIT.
//     If req_s=1 and fill_done=0, stay in IDLE; the request is held off with no error.
//   - WAIT: cnt decrements once per edge.
//     On the edge where cnt==0, ard_data<=ram_q.
//     If req_s=1 on that edge: ard_ack<=1, go ACK.
//     If req_s=0 on that edge: proto_err<=1, go IDLE, no ack.
//     A req_s drop earlier in WAIT is evaluated only on the cnt==0 edge.
//   - ACK: ard_ack held 1 and ard_data held stable.
//     When req_s=0: ard_ack<=0, rd_count<=sat(rd_count+1), go IDLE.
//  Latency
//   - Edge 0 is the first edge sampling ard_req=1.
//   - ram_addr updates on edge SYNC_STAGES.
//   - ard_data and ard_ack update on edge SYNC_STAGES+RD_LAT+1 (edge 5 with defaults).
//   - From req_s=0 in ACK, ard_ack falls on the next edge.
//  Data path rules
//   - ram_addr and ard_data hold their last values between transactions; they are never cleared except by reset.
//   - ram_addr changes only on the IDLE->WAIT transition.
//  Boundaries
//   - Address 16'hFFFF is a legal read; there is no wrap logic.
//   - rd_count saturates at 16'hFFFF and does not roll over.
//   - fill_done falling during WAIT or ACK does not abort the current transaction; it only blocks new ones.
//   - A new request is not accepted until ACK->IDLE has completed and req_s is seen high again in IDLE.
//   - proto_err clears only on reset.
// STRUCTURE
//  - Shared include file ram_if_defs.vh: state encodings (IDLE=2'd0, WAIT=2'd1, ACK=2'd2),
//    default ADDR_W and DATA_W, and RD_LAT shared with the RAM wrapper.
//  - One sub-module, bit_sync: SYNC_STAGES-deep synchroniser with async active-low reset.
//  - Top level holds the FSM, wait counter, and output registers.
// TESTING
//  1. fill_done=1, RAM preloaded mem[a]=a[7:0]; req with addr 16'h0010
//     -> ram_addr=16'h0010 after edge 2; ard_data=8'h10 and ard_ack=1 after edge 5.
//     After req drops, ack falls after sync+1; rd_count=1.
//  2. req high while fill_done=0 for 20 cycles, then fill_done=1
//     -> no ack while fill_done=0; busy stays 0; read completes after fill_done rises; proto_err=0.
//  3. req dropped on edge 2 after rise, addr 16'h0020
//     -> ard_data=8'h20 captured, ard_ack never rises, proto_err=1, FSM back to IDLE.
//  4. reset_n pulsed low during WAIT
//     -> all outputs 0 immediately; the next clean request to 16'hFFFF returns 8'hFF.
//  5. 65537 back-to-back reads (rd_count preloaded via force to 16'hFFFE)
//     -> rd_count goes 16'hFFFF and then stays at 16'hFFFF.
//  6. ard_addr toggled randomly while in ACK
//     -> ram_addr and ard_data unchanged until the next IDLE->WAIT transition.

Source files
------------

// File: rtl/ram_readback_if_pkg.sv
// Shared definitions for the RAM read-back interface: default widths and
// latencies, FSM state encoding and a saturating counter helper.
package ram_readback_if_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 8;
    localparam int RD_LAT_DEF      = 2;   // shared with the RAM wrapper
    localparam int SYNC_STAGES_DEF = 2;

    // Wait counter must hold RD_LAT up to 7.
    localparam int CNT_W      = 3;
    localparam int RD_COUNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } rb_state_t;

    // Increment that sticks at all-ones instead of rolling over.
    function automatic logic [RD_COUNT_W-1:0] sat_inc(input logic [RD_COUNT_W-1:0] v);
        return (v == '1) ? v : v + RD_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/ram_readback_if_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous control bit.
// All flops clear on reset so the synchronised output starts low.
module ram_readback_if_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    // Shift the raw input through the flop chain, oldest sample at the top bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/ram_readback_if.sv
// Arduino read-out stage: synchronises the 4-phase request, drives the RAM
// read address, waits the RAM latency and returns the byte with an ack.
module ram_readback_if
    import ram_readback_if_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RD_LAT      = RD_LAT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fill_done,
    input  logic                  ard_req,
    input  logic [ADDR_W-1:0]     ard_addr,
    input  logic [DATA_W-1:0]     ram_q,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ard_data,
    output logic                  ard_ack,
    output logic                  busy,
    output logic                  proto_err,
    output logic [RD_COUNT_W-1:0] rd_count
);

    logic                  req_s;

    rb_state_t             state_reg,     state_next;
    logic [CNT_W-1:0]      cnt_reg,       cnt_next;
    logic [ADDR_W-1:0]     ram_addr_reg,  ram_addr_next;
    logic [DATA_W-1:0]     ard_data_reg,  ard_data_next;
    logic                  ard_ack_reg,   ard_ack_next;
    logic                  proto_err_reg, proto_err_next;
    logic [RD_COUNT_W-1:0] rd_count_reg,  rd_count_next;

    ram_readback_if_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ard_req),
        .q       (req_s)
    );

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            ram_addr_reg  <= '0;
            ard_data_reg  <= '0;
            ard_ack_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
            rd_count_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ram_addr_reg  <= ram_addr_next;
            ard_data_reg  <= ard_data_next;
            ard_ack_reg   <= ard_ack_next;
            proto_err_reg <= proto_err_next;
            rd_count_reg  <= rd_count_next;
        end
    end

    // Next-state logic: everything holds unless a transition updates it.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ram_addr_next  = ram_addr_reg;
        ard_data_next  = ard_data_reg;
        ard_ack_next   = ard_ack_reg;
        proto_err_next = proto_err_reg;
        rd_count_next  = rd_count_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // Requests are held off silently until the fill stage is done.
                // ard_addr is stable around req rise, so it is safe to sample here.
                if (req_s && fill_done) begin
                    ram_addr_next = ard_addr;
                    cnt_next      = CNT_W'(RD_LAT);
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An early req drop is only judged once the data is in hand.
                if (cnt_reg == '0) begin
                    ard_data_next = ram_q;
                    if (req_s) begin
                        ard_ack_next = 1'b1;
                        state_next   = ST_ACK;
                    end else begin
                        proto_err_next = 1'b1;
                        state_next     = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ard_ack_next  = 1'b0;
                    rd_count_next = sat_inc(rd_count_reg);
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ram_addr  = ram_addr_reg;
    assign ard_data  = ard_data_reg;
    assign ard_ack   = ard_ack_reg;
    assign proto_err = proto_err_reg;
    assign rd_count  = rd_count_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule
